// File: rtl/ula_nibble_seq.sv
// Nibble-serial sequencer: runs NIBBLES x 4-bit operations through one 74181-style slice, LSB nibble first.
// Define ULA_SEQ_EQ_EN to accumulate the slice's A=B flag into eq_o; otherwise eq_o is tied low.
module ula_nibble_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  input  logic [3:0]   op_s_i,
  input  logic         op_m_i,
  input  logic         op_cin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o,
  output logic         cout_o,
  output logic         eq_o,
  output logic [3:0]   alu_a_o,
  output logic [3:0]   alu_b_o,
  output logic [3:0]   alu_s_o,
  output logic         alu_m_o,
  output logic         alu_c_in_o,
  input  logic [3:0]   alu_f_i,
  input  logic         alu_c_out_i,
  input  logic         alu_a_eq_b_i
);

  localparam int                IDX_W    = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;
  logic [NIBBLES-1:0][3:0] result_q, result_d;
  logic [NIBBLES-1:0][3:0] acc_q, acc_d;
  logic [NIBBLES-1:0][3:0] a_q, b_q;
  logic [3:0]              s_q;
  logic                    m_q;
  logic                    load;

`ifdef ULA_SEQ_EQ_EN
  logic eq_acc_q, eq_acc_d;
  logic eq_q, eq_d;
`else
  logic unused_a_eq_b;
  assign unused_a_eq_b = alu_a_eq_b_i;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    result_d = result_q;
    acc_d    = acc_q;
    load     = 1'b0;
`ifdef ULA_SEQ_EQ_EN
    eq_acc_d = eq_acc_q;
    eq_d     = eq_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load     = 1'b1;
          idx_d    = '0;
          carry_d  = op_cin_i;
`ifdef ULA_SEQ_EQ_EN
          eq_acc_d = 1'b1;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d[idx_q] = alu_f_i;
        carry_d      = alu_c_out_i;
`ifdef ULA_SEQ_EQ_EN
        eq_acc_d     = eq_acc_q & alu_a_eq_b_i;
`endif
        if (idx_q == LAST_IDX) begin
          // Final nibble: publish the value including this cycle's slice output.
          result_d = acc_d;
          cout_d   = alu_c_out_i;
`ifdef ULA_SEQ_EQ_EN
          eq_d     = eq_acc_d;
`endif
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      result_q <= '0;
`ifdef ULA_SEQ_EQ_EN
      eq_acc_q <= 1'b0;
      eq_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      result_q <= result_d;
`ifdef ULA_SEQ_EQ_EN
      eq_acc_q <= eq_acc_d;
      eq_q     <= eq_d;
`endif
    end
  end

  // NOTE: operand shadows and the accumulator carry no reset; they are loaded or fully rewritten before use.
  always_ff @(posedge clk_i) begin
    if (load) begin
      a_q <= op_a_i;
      b_q <= op_b_i;
      s_q <= op_s_i;
      m_q <= op_m_i;
    end
    acc_q <= acc_d;
  end

  always_comb begin
    alu_a_o    = 4'h0;
    alu_b_o    = 4'h0;
    alu_s_o    = 4'h0;
    alu_m_o    = 1'b0;
    alu_c_in_o = 1'b0;
    if (state_q == S_RUN) begin
      alu_a_o    = a_q[idx_q];
      alu_b_o    = b_q[idx_q];
      alu_s_o    = s_q;
      alu_m_o    = m_q;
      alu_c_in_o = carry_q;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign cout_o   = cout_q;
`ifdef ULA_SEQ_EQ_EN
  assign eq_o     = eq_q;
`else
  assign eq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Directed bench for ula_nibble_seq with a behavioural 74181 slice closing the loop.
module tb_ula_nibble_seq;

`ifdef ULA_SEQ_EQ_EN
  localparam logic EQ_ON = 1'b1;
`else
  localparam logic EQ_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_s;
  logic        op_m, op_cin;
  logic        busy, done, cout, eq;
  logic [15:0] result;
  logic [3:0]  alu_a, alu_b, alu_s, alu_f;
  logic        alu_m, alu_c_in, alu_c_out, alu_a_eq_b;

  int n_checks = 0;
  int n_fail   = 0;

  ula_nibble_seq #(.NIBBLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .op_s_i       (op_s),
    .op_m_i       (op_m),
    .op_cin_i     (op_cin),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result),
    .cout_o       (cout),
    .eq_o         (eq),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_s_o      (alu_s),
    .alu_m_o      (alu_m),
    .alu_c_in_o   (alu_c_in),
    .alu_f_i      (alu_f),
    .alu_c_out_i  (alu_c_out),
    .alu_a_eq_b_i (alu_a_eq_b)
  );

  // Active-high 74181 slice: c_in=1 means no carry in, c_out=0 means carry out.
  logic [3:0] sx, sy;
  logic [4:0] ssum;
  always_comb begin
    sx   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    sy   = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    ssum = {1'b0, sx} + {1'b0, sy} + {4'b0, ~alu_c_in};
    alu_f = ssum[3:0];
    if (alu_m) begin
      case (alu_s)
        4'h0: alu_f = ~alu_a;
        4'h1: alu_f = ~(alu_a | alu_b);
        4'h2: alu_f = ~alu_a & alu_b;
        4'h3: alu_f = 4'h0;
        4'h4: alu_f = ~(alu_a & alu_b);
        4'h5: alu_f = ~alu_b;
        4'h6: alu_f = alu_a ^ alu_b;
        4'h7: alu_f = alu_a & ~alu_b;
        4'h8: alu_f = ~alu_a | alu_b;
        4'h9: alu_f = ~(alu_a ^ alu_b);
        4'hA: alu_f = alu_b;
        4'hB: alu_f = alu_a & alu_b;
        4'hC: alu_f = 4'hF;
        4'hD: alu_f = alu_a | ~alu_b;
        4'hE: alu_f = alu_a | alu_b;
        default: alu_f = alu_a;
      endcase
    end
    alu_c_out  = ~ssum[4];
    alu_a_eq_b = (alu_f == 4'hF);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation and leaves the bench in the first RUN cycle.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cycle 1 is the first RUN cycle, done is due in cycle 5.
  task automatic wait_done(input string tag);
    int cycles;
    cycles = 1;
    while (done !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
    check(tag, cycles, 5);
  endtask

  logic [3:0] xor_a_seq [4];
  int         done_cnt;
  logic [15:0] seen_result;

  initial begin
    xor_a_seq = '{4'h0, 4'hF, 4'h5, 4'hA};
    rst = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;

    // Reset state
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 16'h0000);
    check("rst_cout", cout, 0);
    check("rst_eq", eq, 0);
    check("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 0);
    rst = 1'b0;
    step();

    // Logic XOR with alu_a nibble sequence and exact latency
    start_op(16'hA5F0, 16'h5A0F, 4'b0110, 1'b1, 1'b1);
    check("xor_busy_rise", busy, 1);
    check("xor_alu_s", {alu_s, alu_m}, {4'b0110, 1'b1});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("xor_alu_a_%0d", i), alu_a, xor_a_seq[i]);
      check($sformatf("xor_no_done_%0d", i), done, 0);
      step();
    end
    check("xor_done", done, 1);
    check("xor_result", result, 16'hFFFF);
    check("xor_alu_idle", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 0);
    step();
    check("xor_done_pulse", done, 0);
    check("xor_busy_fall", busy, 0);
    check("xor_result_held", result, 16'hFFFF);

    // Arithmetic carry ripple: FFFF + 0001, no input carry
    start_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ripple_cin_%0d", i), alu_c_in, (i == 0) ? 1'b1 : 1'b0);
      step();
    end
    check("ripple_done", done, 1);
    check("ripple_result", result, 16'h0000);
    check("ripple_cout", cout, 0);
    step();

    // Equality: A == B
    start_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b1);
    wait_done("eq_same_latency");
    check("eq_same_result", result, 16'hFFFF);
    check("eq_same_cout", cout, 1);
    check("eq_same_eq", eq, EQ_ON);
    step();

    // Equality: A != B in nibble 0 only
    start_op(16'h3C3C, 16'h3C3D, 4'b0110, 1'b0, 1'b1);
    wait_done("eq_diff_latency");
    check("eq_diff_result", result, 16'hFFFE);
    check("eq_diff_eq", eq, 0);
    step();

    // Busy rejection: second start during RUN cycle 2 is ignored
    start_op(16'h1111, 16'h2222, 4'b1110, 1'b1, 1'b1);
    step();
    op_a = 16'hFFFF; start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    seen_result = 16'h0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) begin
        done_cnt++;
        seen_result = result;
      end
      step();
    end
    check("busy_rej_done_count", done_cnt, 1);
    check("busy_rej_result", seen_result, 16'h3333);
    check("busy_rej_idle", busy, 0);

    // Reset during nibble 2 aborts and clears the held result
    start_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1);
    step(); step();
    check("abort_at_nibble2", alu_a, 4'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result", result, 16'h0000);
    check("abort_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) done_cnt++;
      step();
    end
    check("abort_no_done", done_cnt, 0);

    // Normal operation after abort: 1234 + 1111
    start_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1);
    wait_done("post_abort_latency");
    check("post_abort_result", result, 16'h2345);
    check("post_abort_cout", cout, 1);
    step();

    // rst and start together: start is dropped
    op_a = 16'h0F0F; op_b = 16'h00FF; op_s = 4'b1011; op_m = 1'b1; op_cin = 1'b1;
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_result", result, 16'h0000);
    step();
    check("rst_start_still_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
